// File: rtl/shift_unit.sv
`default_nettype none
// ============================================================================
// shift_unit : pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready.
// Rotate wrap path built only when SHIFT_UNIT_ROTATE_EN is defined.  Rev 1.0
// ============================================================================
module shift_unit #(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 5,
  localparam int SHAMT_W         = $clog2(WIDTH),
  localparam int LAT             = (SHAMT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFT_UNIT_ROTATE_EN
  localparam logic [1:0] OP_ROR = 2'b11;
`endif

  // One barrel level: shift by 2^k with the fill selected by the opcode.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input int               k,
    input logic [1:0]       op,
    input logic             sign
  );
    logic [WIDTH-1:0] right;
    logic [WIDTH-1:0] ones;
    int               amt;
    amt   = 1 << k;
    ones  = '1;
    right = d >> amt;
    case (op)
      OP_SLL:  shift_level = d << amt;
      OP_SRL:  shift_level = right;
      OP_SRA:  shift_level = sign ? (right | ~(ones >> amt)) : right;
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROR:  shift_level = right | (d << (WIDTH - amt));
`endif
      default: shift_level = right;
    endcase
  endfunction

  // Stage registers are numbered 1..LAT; stage LAT drives the outputs.
  logic [LAT:1]                 st_valid;
  logic [LAT:1][WIDTH-1:0]      st_data;
  logic [LAT:1][SHAMT_W-1:0]    st_shamt;
  logic [LAT:1][1:0]            st_op;
  logic [LAT:1]                 st_sign;
  logic [LAT:1][TAG_W-1:0]      st_tag;

  // Source of each stage's combinational levels: index 0 is the input port.
  logic [LAT-1:0]               src_valid;
  logic [LAT-1:0][WIDTH-1:0]    src_data;
  logic [LAT-1:0][SHAMT_W-1:0]  src_shamt;
  logic [LAT-1:0][1:0]          src_op;
  logic [LAT-1:0]               src_sign;
  logic [LAT-1:0][TAG_W-1:0]    src_tag;
  logic [LAT-1:0][WIDTH-1:0]    nxt_data;

  logic stall;
  logic unused_stage_bits;

  assign out_valid = st_valid[LAT];
  assign out_data  = st_data[LAT];
  assign out_tag   = st_tag[LAT];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  // Sign is latched from the original operand so intermediate values never alter it.
  always_comb begin
    src_valid    = '0;
    src_data     = '0;
    src_shamt    = '0;
    src_op       = '0;
    src_sign     = '0;
    src_tag      = '0;
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_op[0]    = in_op;
    src_sign[0]  = (in_op == OP_SRA) & in_data[WIDTH-1];
    src_tag[0]   = in_tag;
    for (int s = 1; s < LAT; s++) begin
      src_valid[s] = st_valid[s];
      src_data[s]  = st_data[s];
      src_shamt[s] = st_shamt[s];
      src_op[s]    = st_op[s];
      src_sign[s]  = st_sign[s];
      src_tag[s]   = st_tag[s];
    end
  end

  always_comb begin
    nxt_data = '0;
    for (int s = 0; s < LAT; s++) begin
      nxt_data[s] = src_data[s];
      for (int k = 0; k < SHAMT_W; k++) begin
        if (((k / LEVELS_PER_STAGE) == s) && src_shamt[s][k]) begin
          nxt_data[s] = shift_level(nxt_data[s], k, src_op[s], src_sign[s]);
        end
      end
    end
  end

  // Every stage advances together (bubbles included) unless the output is blocked.
  always_ff @(posedge clock) begin
    if (reset) begin
      st_valid <= '0;
      st_data  <= '0;
      st_shamt <= '0;
      st_op    <= '0;
      st_sign  <= '0;
      st_tag   <= '0;
    end else if (!stall) begin
      for (int s = 0; s < LAT; s++) begin
        st_valid[s+1] <= src_valid[s];
        st_data[s+1]  <= nxt_data[s];
        st_shamt[s+1] <= src_shamt[s];
        st_op[s+1]    <= src_op[s];
        st_sign[s+1]  <= src_sign[s];
        st_tag[s+1]   <= src_tag[s];
      end
    end
  end

  // Last-stage control fields have no consumer.
  assign unused_stage_bits = &{1'b0, st_shamt, st_op, st_sign};

endmodule
`default_nettype wire

// File: tb/tb_shift_unit.sv
`default_nettype none
// tb_shift_unit: scoreboard bench for shift_unit at 32/2, 8/1 and 64/6 configurations.
module tb_shift_unit;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: WIDTH 32, LEVELS_PER_STAGE 2, TAG_W 5 (LAT 3)
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [4:0]  a_in_shamt;
  logic [1:0]  a_in_op;
  logic [4:0]  a_in_tag, a_out_tag;
  // Instance B: WIDTH 8, LEVELS_PER_STAGE 1, TAG_W 3 (LAT 3)
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_data, b_out_data;
  logic [2:0]  b_in_shamt;
  logic [1:0]  b_in_op;
  logic [2:0]  b_in_tag, b_out_tag;
  // Instance C: WIDTH 64, LEVELS_PER_STAGE 6, TAG_W 4 (LAT 1)
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [63:0] c_in_data, c_out_data;
  logic [5:0]  c_in_shamt;
  logic [1:0]  c_in_op;
  logic [3:0]  c_in_tag, c_out_tag;

  shift_unit #(.WIDTH(32), .LEVELS_PER_STAGE(2), .TAG_W(5)) u_a (
    .clock(clock), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_shamt(a_in_shamt), .in_op(a_in_op), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_tag(a_out_tag));

  shift_unit #(.WIDTH(8), .LEVELS_PER_STAGE(1), .TAG_W(3)) u_b (
    .clock(clock), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_shamt(b_in_shamt), .in_op(b_in_op), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag));

  shift_unit #(.WIDTH(64), .LEVELS_PER_STAGE(6), .TAG_W(4)) u_c (
    .clock(clock), .reset(reset),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .in_shamt(c_in_shamt), .in_op(c_in_op), .in_tag(c_in_tag),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_tag(c_out_tag));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference shifter written directly from the op definitions.
  function automatic logic [63:0] model(input logic [63:0] din, input int s,
                                        input logic [1:0] op, input int w);
    logic [63:0] m;
    logic [63:0] d;
    logic [63:0] r;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d = din & m;
    case (op)
      2'b00: r = (d << s) & m;
      2'b01: r = d >> s;
      2'b10: begin
        r = d >> s;
        if (d[w-1]) r = r | (m & ~(m >> s));
      end
      default: begin
`ifdef SHIFT_UNIT_ROTATE_EN
        r = (s == 0) ? d : (((d >> s) | (d << (w - s))) & m);
`else
        r = d >> s;
`endif
      end
    endcase
    return r;
  endfunction

  // Scoreboards: expected {tag, data} pushed on acceptance, popped on output transfer.
  logic [71:0] a_q[$];
  logic [71:0] b_q[$];
  logic [71:0] c_q[$];
  logic [71:0] a_e, b_e, c_e;
  int a_pops = 0, b_pops = 0, c_pops = 0;

  always @(negedge clock) begin
    if (reset) a_q.delete();
    else begin
      if (a_out_valid && a_out_ready) begin
        chk("a_sb_pending", 64'(a_q.size() != 0), 64'd1);
        if (a_q.size() != 0) begin
          a_e = a_q.pop_front();
          chk("a_sb_data", 64'(a_out_data), a_e[63:0]);
          chk("a_sb_tag", 64'(a_out_tag), 64'(a_e[71:64]));
          a_pops++;
        end
      end
      if (a_in_valid && a_in_ready)
        a_q.push_back({8'(a_in_tag), model(64'(a_in_data), int'(a_in_shamt), a_in_op, 32)});
    end
  end

  always @(negedge clock) begin
    if (reset) b_q.delete();
    else begin
      if (b_out_valid && b_out_ready) begin
        chk("b_sb_pending", 64'(b_q.size() != 0), 64'd1);
        if (b_q.size() != 0) begin
          b_e = b_q.pop_front();
          chk("b_sb_data", 64'(b_out_data), b_e[63:0]);
          chk("b_sb_tag", 64'(b_out_tag), 64'(b_e[71:64]));
          b_pops++;
        end
      end
      if (b_in_valid && b_in_ready)
        b_q.push_back({8'(b_in_tag), model(64'(b_in_data), int'(b_in_shamt), b_in_op, 8)});
    end
  end

  always @(negedge clock) begin
    if (reset) c_q.delete();
    else begin
      if (c_out_valid && c_out_ready) begin
        chk("c_sb_pending", 64'(c_q.size() != 0), 64'd1);
        if (c_q.size() != 0) begin
          c_e = c_q.pop_front();
          chk("c_sb_data", 64'(c_out_data), c_e[63:0]);
          chk("c_sb_tag", 64'(c_out_tag), 64'(c_e[71:64]));
          c_pops++;
        end
      end
      if (c_in_valid && c_in_ready)
        c_q.push_back({8'(c_in_tag), model(c_in_data, int'(c_in_shamt), c_in_op, 64)});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op,
                         input logic [4:0] tag);
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_shamt = s;
    a_in_op    = op;
    a_in_tag   = tag;
  endtask

  logic [31:0] bb_d   [5] = '{32'h0000_0001, 32'hF000_0000, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
  logic [4:0]  bb_sh  [5] = '{5'd31, 5'd4, 5'd31, 5'd0, 5'd0};
  logic [1:0]  bb_op  [5] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11};
  logic [31:0] bb_exp [5] = '{32'h8000_0000, 32'h0F00_0000, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

  logic [31:0] bp_d  [4] = '{32'hA5A5_A5A5, 32'h8000_1234, 32'hFFFF_0000, 32'h1234_5678};
  logic [4:0]  bp_sh [4] = '{5'd4, 5'd8, 5'd16, 5'd12};
  logic [1:0]  bp_op [4] = '{2'b00, 2'b10, 2'b01, 2'b11};

`ifdef SHIFT_UNIT_ROTATE_EN
  localparam logic [31:0] ROR_EXP = 32'h8000_0000;
`else
  localparam logic [31:0] ROR_EXP = 32'h0000_0000;
`endif

  initial begin
    int sent;
    int pops0;
    reset = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_in_shamt = '0; a_in_op = '0; a_in_tag = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_shamt = '0; b_in_op = '0; b_in_tag = '0; b_out_ready = 1;
    c_in_valid = 0; c_in_data = '0; c_in_shamt = '0; c_in_op = '0; c_in_tag = '0; c_out_ready = 1;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data", 64'(a_out_data), 64'd0);
    chk("rst_out_tag", 64'(a_out_tag), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_c_out_valid", 64'(c_out_valid), 64'd0);

    // Single SRA and its latency
    drive_a(32'h8000_0000, 5'd2, 2'b10, 5'd7);
    step();
    a_in_valid = 1'b0;
    chk("lat_cycle1_valid", 64'(a_out_valid), 64'd0);
    step();
    chk("lat_cycle2_valid", 64'(a_out_valid), 64'd0);
    step();
    chk("lat_cycle3_valid", 64'(a_out_valid), 64'd1);
    chk("sra_data", 64'(a_out_data), 64'hE000_0000);
    chk("sra_tag", 64'(a_out_tag), 64'd7);
    step();

    // Back-to-back: one result per cycle, in order
    for (int c = 0; c < 10; c++) begin
      if (c < 5) drive_a(bb_d[c], bb_sh[c], bb_op[c], 5'(c + 1));
      else a_in_valid = 1'b0;
      chk("bb_valid", 64'(a_out_valid), 64'(c >= 3 && c < 8));
      if (c >= 3 && c < 8) chk("bb_data", 64'(a_out_data), 64'(bb_exp[c-3]));
      step();
    end

    // Rotate (or SRL alias) of 1 by 1
    drive_a(32'h0000_0001, 5'd1, 2'b11, 5'd9);
    step();
    a_in_valid = 1'b0;
    step();
    step();
    chk("ror_valid", 64'(a_out_valid), 64'd1);
    chk("ror_data", 64'(a_out_data), 64'(ROR_EXP));
    step();

    // Backpressure: hold out_ready low for 5 cycles once output appears
    sent  = 0;
    pops0 = a_pops;
    for (int c = 0; c < 20; c++) begin
      a_out_ready = !(c >= 3 && c < 8);
      if (sent < 4) drive_a(bp_d[sent], bp_sh[sent], bp_op[sent], 5'(20 + sent));
      else a_in_valid = 1'b0;
      #1;
      if (c >= 3 && c < 8) begin
        chk("bp_in_ready", 64'(a_in_ready), 64'd0);
        chk("bp_hold_valid", 64'(a_out_valid), 64'd1);
        chk("bp_hold_data", 64'(a_out_data), model(64'(bp_d[0]), int'(bp_sh[0]), bp_op[0], 32));
      end
      #2;
      if (a_in_valid && a_in_ready) sent++;
      step();
    end
    chk("bp_sent", 64'(sent), 64'd4);
    chk("bp_delivered", 64'(a_pops - pops0), 64'd4);

    // Reset one cycle after issuing two operations
    drive_a(32'h1111_1111, 5'd1, 2'b00, 5'd1);
    step();
    drive_a(32'h2222_2222, 5'd2, 2'b01, 5'd2);
    step();
    reset = 1'b1;
    drive_a(32'h3333_3333, 5'd3, 2'b10, 5'd3);
    step();
    reset = 1'b0;
    a_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rst_mid_out_valid", 64'(a_out_valid), 64'd0);
      chk("rst_mid_in_ready", 64'(a_in_ready), 64'd1);
      step();
    end

    // Random sweep on the 8-bit and 64-bit configurations
    for (int c = 0; c < 300; c++) begin
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_data   = 8'($urandom);
      b_in_shamt  = 3'($urandom);
      b_in_op     = 2'($urandom);
      b_in_tag    = 3'($urandom);
      b_out_ready = ($urandom_range(0, 3) != 0);
      c_in_valid  = ($urandom_range(0, 3) != 0);
      c_in_data   = {$urandom, $urandom};
      c_in_shamt  = 6'($urandom);
      c_in_op     = 2'($urandom);
      c_in_tag    = 4'($urandom);
      c_out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    b_in_valid = 0; b_out_ready = 1;
    c_in_valid = 0; c_out_ready = 1;
    repeat (8) step();

    chk("a_drained", 64'(a_q.size()), 64'd0);
    chk("b_drained", 64'(b_q.size()), 64'd0);
    chk("c_drained", 64'(c_q.size()), 64'd0);
    chk("b_results_seen", 64'(b_pops > 100), 64'd1);
    chk("c_results_seen", 64'(c_pops > 100), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_unit.md
# shift_unit

Pipelined, parametrised barrel shifter for the processor execute stage. Performs logical left, logical right, arithmetic right and (optionally) rotate-right on a WIDTH-bit operand by a run-time amount, with a valid/ready handshake and a pass-through tag. It replaces single-purpose fixed-distance shift blocks with one unit that covers every shift opcode at any distance.

## Interface
- WIDTH, 32, operand width; power of two, ≥ 4
- LEVELS_PER_STAGE, 2, barrel levels between pipeline registers; 1..SHAMT_W
- TAG_W, 5, sideband tag width, e.g. destination register; ≥ 1
- Derived localparams, not overridable: SHAMT_W = log2(WIDTH); LAT = ceil(SHAMT_W / LEVELS_PER_STAGE)

- clock  in  1  the single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  input operation present
- in_ready  out  1  unit accepts input this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  SHAMT_W  shift distance, 0..WIDTH-1
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- in_tag  in  TAG_W  carried unchanged to the output
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  shifted result
- out_tag  out  TAG_W  tag of the result

## Operation
- Shift network: SHAMT_W levels. Level k shifts by 2^k when in_shamt[k] = 1, otherwise passes the value through. Levels are applied in ascending k order.
- Fill per op:
  - SLL: zeros enter at the LSB.
  - SRL: zeros enter at the MSB.
  - SRA: the original operand's bit WIDTH-1 enters at the MSB. The sign comes from the input operand, not the intermediate value.
  - ROR: bits leaving the LSB re-enter at the MSB.
- in_shamt = 0 returns in_data unchanged for every op.
- Pipeline: LAT register stages, each holding valid, partial data, remaining shamt bits, op, sign bit and tag.
  - A register follows every LEVELS_PER_STAGE levels; the last stage may hold fewer levels.
  - The last stage register drives out_* directly; there are no combinational paths from in_* to out_*.
- Stall: stall = out_valid & ~out_ready.
  - While stall is high, every stage holds.
  - While stall is low, every stage advances, including bubbles. Bubbles are not compacted.
- in_ready = ~stall. A transfer occurs when in_valid & in_ready.
- out_data and out_tag hold stable while out_valid & ~out_ready.
- Results leave in acceptance order.

## Timing
- Latency: an operation accepted at edge N has out_valid = 1 after edge N+LAT-1, visible in the cycle following edge N+LAT-1. With defaults (LAT = 3), a result accepted at cycle 0 appears in cycle 3.
- Throughput: 1 operation per cycle when out_ready is held high.
- Reset, synchronous:
  - All stage valid bits clear; out_valid = 0, out_data = 0, out_tag = 0.
  - in_ready = 1 in the first cycle after reset.
  - in_valid is ignored during any cycle in which reset is high.
- Reset mid-operation: all in-flight operations are discarded, and none appears at the output afterwards.
- Simultaneous stall release and input: when out_ready rises in a cycle where out_valid = 1, that cycle both drains the output and accepts in_data if in_valid = 1.
- out_ready low with out_valid = 0 does not stall the pipeline.

## Configuration
- SHIFT_UNIT_ROTATE_EN:
  - Defined: op 11 performs rotate-right as described above.
  - Undefined: the rotate wrap path is not built, and op 11 executes exactly as SRL (op 01).

## Test plan
- Reset, then in_op = SRA, in_data = 0x80000000, in_shamt = 2, tag = 7 -> out_valid in cycle 3, out_data = 0xE0000000, out_tag = 7.
- Back-to-back with out_ready = 1:
  - SLL 0x00000001 by 31 -> 0x80000000
  - SRL 0xF0000000 by 4 -> 0x0F000000
  - SRA 0x7FFFFFFF by 31 -> 0x00000000
  - Any op by 0 on 0xDEADBEEF -> 0xDEADBEEF
  - Expect one result per cycle, in order.
- ROR 0x00000001 by 1 -> 0x80000000 with SHIFT_UNIT_ROTATE_EN defined; 0x00000000 without it.
- Backpressure: issue 4 operations back-to-back and hold out_ready = 0 for 5 cycles once out_valid rises.
  - in_ready = 0 throughout the hold.
  - out_data stays constant during the hold.
  - After release, all 4 results arrive in order, with no loss or duplication.
- Assert reset 1 cycle after issuing 2 operations -> out_valid stays 0 for the next LAT+2 cycles; in_ready = 1.
- Sweep: WIDTH = 8 with LEVELS_PER_STAGE = 1 (LAT = 3), and WIDTH = 64 with LEVELS_PER_STAGE = 6 (LAT = 1). Apply random ops and shamt, and check every result against a reference model.
